// File: rtl/arb2x1_ctrl.sv
// arb2x1_ctrl: two-requester round-robin arbiter feeding a one-word output register
// ports: req0/req1 valid-ready-data in, out valid-ready-data out, mux_sel drives the shared 2:1 data mux
// macro ARB2X1_STATS_EN adds saturating 8-bit grant counters gnt_cnt0/gnt_cnt1
module arb2x1_ctrl #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [SIZE-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [SIZE-1:0] req1_data,
  output logic            req1_ready,
  output logic            mux_sel,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  input  logic            out_ready
`ifdef ARB2X1_STATS_EN
  ,
  output logic [7:0]      gnt_cnt0,
  output logic [7:0]      gnt_cnt1
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t r_state, w_next;
  logic r_prio, r_sel, w_any, w_win, w_acc, w_xfer;
  logic [SIZE-1:0] r_data;
  always_comb begin
    w_any = req0_valid | req1_valid;
    w_win = (req0_valid & req1_valid) ? r_prio : req1_valid;
    w_acc = ~rst & ((r_state == EMPTY) | out_ready);
    w_xfer = w_any & w_acc;
    w_next = w_xfer ? FULL : (out_ready ? EMPTY : r_state);
    req0_ready = w_xfer & ~w_win;
    req1_ready = w_xfer & w_win;
    mux_sel = w_any ? w_win : r_sel;
    out_valid = (r_state == FULL);
    out_data = r_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= EMPTY;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data <= '0;
      r_prio <= 1'b0;
      r_sel <= 1'b0;
    end else begin
      if (w_any) r_sel <= w_win;
      if (w_xfer) begin
        r_data <= w_win ? req1_data : req0_data;
        r_prio <= ~w_win;
      end
    end
`ifdef ARB2X1_STATS_EN
  logic [7:0] r_cnt0, r_cnt1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (req0_ready && r_cnt0 != 8'hFF) r_cnt0 <= r_cnt0 + 8'd1;
      if (req1_ready && r_cnt1 != 8'hFF) r_cnt1 <= r_cnt1 + 8'd1;
    end
  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_arb2x1_ctrl.sv
// tb_arb2x1_ctrl: self-checking bench for arb2x1_ctrl against a queue-based model
module tb_arb2x1_ctrl;
  logic clk = 1'b0, rst = 1'b1, v0 = 1'b0, v1 = 1'b0, ordy = 1'b0;
  logic [3:0] d0 = 4'h0, d1 = 4'h0;
  logic r0, r1, sel, ov;
  logic [3:0] od;
`ifdef ARB2X1_STATS_EN
  logic [7:0] c0, c1;
`endif
  int tests = 0, fails = 0;
  logic [3:0] q[$];
  int m_prio = 0, m_sel = 0, m_c0 = 0, m_c1 = 0;
  logic [3:0] m_last = 4'h0;
  arb2x1_ctrl #(.SIZE(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .mux_sel(sel), .out_valid(ov), .out_data(od), .out_ready(ordy)
`ifdef ARB2X1_STATS_EN
    , .gnt_cnt0(c0), .gnt_cnt1(c1)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int winner();
    if (v0 && v1) return m_prio;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction
  function automatic bit can_acc();
    return !rst && (q.size() == 0 || ordy);
  endfunction
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_prio = 0; m_sel = 0; m_c0 = 0; m_c1 = 0; m_last = 4'h0;
    end else begin
      int w;
      bit c;
      w = winner();
      c = can_acc();
      if (ordy && q.size() != 0) void'(q.pop_front());
      if (w >= 0) m_sel = w;
      if (w >= 0 && c) begin
        m_last = (w == 1) ? d1 : d0;
        q.push_back(m_last);
        m_prio = 1 - w;
        if (w == 0) m_c0 = (m_c0 < 255) ? m_c0 + 1 : 255;
        else m_c1 = (m_c1 < 255) ? m_c1 + 1 : 255;
      end
    end
  end
  initial forever begin
    int w;
    bit c;
    @(negedge clk);
    w = winner();
    c = can_acc();
    chk("out_valid", ov, q.size() != 0);
    chk("out_data", od, m_last);
    chk("req0_ready", r0, c && w == 0);
    chk("req1_ready", r1, c && w == 1);
    chk("mux_sel", sel, (w >= 0) ? w : m_sel);
`ifdef ARB2X1_STATS_EN
    chk("gnt_cnt0", c0, m_c0);
    chk("gnt_cnt1", c1, m_c1);
`endif
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set(bit a, logic [3:0] da, bit b, logic [3:0] db, bit r);
    v0 = a; d0 = da; v1 = b; d1 = db; ordy = r;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("lit_rst_valid", ov, 0);
    chk("lit_rst_data", od, 0);
    tick();
    rst = 1'b0;
    set(1, 4'h5, 0, 4'h0, 1);
    @(negedge clk);
    chk("lit_single_ready", r0, 1);
    chk("lit_single_sel", sel, 0);
    tick();
    set(0, 4'h0, 0, 4'h0, 0);
    @(negedge clk);
    chk("lit_single_valid", ov, 1);
    chk("lit_single_data", od, 4'h5);
    tick();
    do_reset();
    set(1, 4'h3, 1, 4'hC, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("lit_cont_data", od, (i % 2 == 1) ? 4'h3 : 4'hC);
      chk("lit_cont_sel", sel, i % 2);
      tick();
    end
    set(1, 4'h7, 0, 4'h0, 1);
    @(negedge clk);
    chk("lit_cont_last", od, 4'hC);
    tick();
    set(1, 4'h3, 1, 4'hC, 0);
    repeat (3) begin
      @(negedge clk);
      chk("lit_bp_data", od, 4'h7);
      chk("lit_bp_r0", r0, 0);
      chk("lit_bp_r1", r1, 0);
      tick();
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("lit_bp_release_r1", r1, 1);
    chk("lit_bp_release_sel", sel, 1);
    tick();
    set(0, 4'h0, 0, 4'h0, 1);
    @(negedge clk);
    chk("lit_bp_new_data", od, 4'hC);
    tick();
    @(negedge clk);
    chk("lit_drain_valid", ov, 0);
    chk("lit_drain_sel", sel, 1);
    tick();
    set(1, 4'hA, 0, 4'h0, 0);
    tick();
    set(0, 4'h0, 0, 4'h0, 0);
    #2;
    chk("lit_full_a", od, 4'hA);
    rst = 1'b1;
    #1;
    chk("lit_async_valid", ov, 0);
    chk("lit_async_data", od, 0);
    tick();
    rst = 1'b0;
    set(1, 4'h1, 1, 4'h2, 1);
    @(negedge clk);
    chk("lit_prio_after_rst", r0, 1);
    tick();
    for (int i = 0; i < 80; i++) begin
      set(1'($urandom % 2), 4'($urandom), 1'($urandom % 2), 4'($urandom), 1'($urandom % 3 != 0));
      tick();
    end
    do_reset();
    set(1, 4'h6, 0, 4'h0, 1);
    repeat (300) tick();
    set(0, 4'h0, 1, 4'h9, 1);
    repeat (2) tick();
    set(0, 4'h0, 0, 4'h0, 1);
    @(negedge clk);
`ifdef ARB2X1_STATS_EN
    chk("lit_cnt0_sat", c0, 255);
    chk("lit_cnt1", c1, 2);
`endif
    chk("lit_final_data", od, 4'h9);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
